// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM state type and sizing helper for the serial arithmetic blocks
package serial_arith_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: single-bit x - y - bin producing difference and borrow
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  // difference and borrow of one bit column
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned A - B, LSB first, result shifted back into A
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             x,
  output logic             y,
  output logic             bin,
  output logic             d,
  output logic             bout
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  full_subtractor u_fs (
    .x    (x),
    .y    (y),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );
  // serial taps and status come straight from registers, never from inputs
  always_comb begin
    x          = a_q[0];
    y          = b_q[0];
    bin        = br_q;
    busy       = (state_q == SHIFT);
    done       = (state_q == DONE);
    diff       = a_q;
    borrow_out = br_q;
  end
  // next state: load on accepted start, shift one bit per cycle, single DONE cycle
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && start) begin
      a_d     = a_in;
      b_d     = b_in;
      br_d    = 1'b0;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      a_d     = {d, a_q[WIDTH-1:1]};
      b_d     = {1'b0, b_q[WIDTH-1:1]};
      br_d    = bout;
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_q == LAST) ? DONE : SHIFT;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
